// File: rtl/bcd_convert_sequencer.sv
// Sequential binary-to-BCD converter, one shift/add-3 step per clock.
// Define BCD_BLANK_EN to replace leading zero digits with the blank code 4'hF.
module bcd_convert_sequencer #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int DW = 4 * DIGITS;
    localparam int SW = DW + BIN_W;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   scratch, adj, scratch_nx;
    logic [DW-1:0]   digits_nx, load_bcd;
    logic            ovf_r;
    logic            last;
`ifdef BCD_BLANK_EN
    logic            lead;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last      = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = CONV;
            CONV:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 on every digit >= 5, then shift the whole scratch left.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[BIN_W+4*d +: 4] >= 4'd5)
                adj[BIN_W+4*d +: 4] = scratch[BIN_W+4*d +: 4] + 4'd3;
        end
        scratch_nx = adj << 1;
    end

    assign digits_nx = scratch_nx[SW-1 -: DW];

    always_comb begin
        load_bcd = digits_nx;
`ifdef BCD_BLANK_EN
        lead = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (lead && digits_nx[4*d +: 4] == 4'd0)
                load_bcd[4*d +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
        if (ovf_r) load_bcd = {DIGITS{4'hE}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            scratch <= '0;
            ovf_r   <= 1'b0;
            out_bcd <= '0;
            out_ovf <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            scratch <= SW'(in_bin);
            cnt     <= CW'(BIN_W);
            ovf_r   <= (64'(in_bin) >= LIMIT);
        end else if (state == CONV) begin
            scratch <= scratch_nx;
            cnt     <= cnt - CW'(1);
            if (last) begin
                out_bcd <= load_bcd;
                out_ovf <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Self-checking bench for bcd_convert_sequencer (default and 10-bit/4-digit builds).
module tb_bcd_convert_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_bin = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_bcd;
    logic       out_ovf;
    logic       busy;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [9:0]  b_in_bin = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_bcd;
    logic        b_out_ovf;
    logic        b_busy;

    int checks = 0;
    int passes = 0;

`ifdef BCD_BLANK_EN
    localparam logic [3:0] Z = 4'hF;
`else
    localparam logic [3:0] Z = 4'h0;
`endif

    always #5 clk = ~clk;

    bcd_convert_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .busy(busy)
    );

    bcd_convert_sequencer #(.BIN_W(10), .DIGITS(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bcd(b_out_bcd), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Decimal reference from plain division.
    function automatic logic [7:0] ref_bcd(input int v);
        logic [7:0] r;
        if (v >= 100) return 8'hEE;
        r = {4'(v / 10), 4'(v % 10)};
        if (v < 10) r[7:4] = Z;
        return r;
    endfunction

    task automatic accept(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        in_bin   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic run(input logic [7:0] b, input logic [7:0] eb,
                       input logic eo, input int hold, input string nm);
        int k;
        out_ready = (hold == 0);
        accept(b);
        wait_out(k);
        check({nm, "_lat"}, k, 8);
        check({nm, "_bcd"}, out_bcd, eb);
        check({nm, "_ovf"}, out_ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({nm, "_hold"}, {out_valid, out_ovf, out_bcd}, {1'b1, eo, eb});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({nm, "_pulse"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run2(input logic [9:0] b, input logic [15:0] eb,
                        input string nm);
        int k;
        k = 0;
        @(negedge clk);
        check({nm, "_rdy"}, b_in_ready, 1);
        b_in_bin   = b;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        while (!b_out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({nm, "_lat"}, k, 10);
        check({nm, "_bcd"}, {b_out_ovf, b_out_bcd}, {1'b0, eb});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [7:0] rb;
        int hold;

        tbl[0] = '{8'd81,  8'h81,       1'b0};
        tbl[1] = '{8'd7,   {Z, 4'h7},   1'b0};
        tbl[2] = '{8'd0,   {Z, 4'h0},   1'b0};
        tbl[3] = '{8'd200, 8'hEE,       1'b1};
        tbl[4] = '{8'd45,  8'h45,       1'b0};
        tbl[5] = '{8'd100, 8'hEE,       1'b1};
        tbl[6] = '{8'd99,  8'h99,       1'b0};
        tbl[7] = '{8'd255, 8'hEE,       1'b1};
        tbl[8] = '{8'd9,   {Z, 4'h9},   1'b0};
        tbl[9] = '{8'd10,  8'h10,       1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_state",
              {in_ready, out_valid, busy, out_ovf, out_bcd}, {4'b1000, 8'h00});
        rst = 1'b0;

        foreach (tbl[i])
            run(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, 0, $sformatf("tbl%0d", i));

        // Backpressure with a competing operand that must not be taken.
        out_ready = 1'b0;
        accept(8'd45);
        wait_out(k);
        check("bp_lat", k, 8);
        in_bin   = 8'd99;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {out_valid, in_ready, out_ovf, out_bcd},
                  {3'b100, 8'h45});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {out_valid, in_ready, busy}, 3'b010);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_accept99", busy, 1);
        wait_out(k);
        check("bp99_lat", k, 8);
        check("bp99_bcd", out_bcd, 8'h99);
        @(posedge clk);
        #1;

        // Reset in the 4th conversion cycle.
        accept(8'd63);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst",
              {in_ready, out_valid, busy, out_ovf, out_bcd}, {4'b1000, 8'h00});
        run(8'd10, 8'h10, 1'b0, 0, "postrst");

        for (int i = 0; i < 24; i++) begin
            rb   = 8'($urandom_range(0, 255));
            hold = int'($urandom_range(0, 3));
            run(rb, ref_bcd(int'(rb)), rb >= 8'd100, hold,
                $sformatf("rnd%0d_%0d", i, rb));
        end

        run2(10'd1023, 16'h1023, "w10_1023");
        run2(10'd8, {Z, Z, Z, 4'h8}, "w10_8");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bcd_convert_sequencer.md
Name: bcd_convert_sequencer

Overview:
Multi-cycle, handshaked binary-to-BCD converter for the ALU result display path. It replaces the unrolled combinational double-dabble with one shift/add-3 iteration per clock. It accepts one operand at a time from the ALU result stage over valid/ready and delivers packed BCD digits to the display driver over valid/ready. It flags results that do not fit in DIGITS digits.

Parameters:
- BIN_W, 8, width of the binary input; equals the number of iterations per conversion.
- DIGITS, 2, number of BCD digits produced; output width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  high only in IDLE.
- in_bin  in  BIN_W  unsigned operand; sampled on the accept edge.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  4*DIGITS  packed digits; digit 0 (ones) in bits [3:0].
- out_ovf  out  1  operand >= 10^DIGITS.
- busy  out  1  high in CONV and DONE.

Behaviour:
- States: IDLE, CONV, DONE.
- Reset: state=IDLE, out_valid=0, out_bcd=0, out_ovf=0, busy=0, iteration counter=0, scratch=0.
  - in_ready is decoded from state, so it reads 1 in the cycle after the reset edge.
  - rst has priority over every other event, including a mid-conversion abort.
- IDLE:
  - Accept occurs when in_valid && in_ready at an edge (E0).
  - On accept: latch in_bin, clear the digit scratch, load the counter with BIN_W, compute and register ovf, go to CONV.
  - in_valid while not in IDLE is ignored; the operand is not queued.
- CONV: at each edge,
  - every 4-bit scratch digit >= 5 gets +3 (mod 16),
  - then {digits, bin} shifts left by 1 with bin MSB entering digit 0 LSB,
  - then the counter decrements.
  - At the edge where the counter goes 1->0, load the out_bcd/out_ovf registers and go to DONE.
- Latency: out_valid first high after edge E0+BIN_W (8 cycles at default). The rate is fixed and independent of data.
- DONE:
  - out_valid=1. out_bcd and out_ovf are held stable while out_ready=0 (unbounded backpressure).
  - On out_valid && out_ready, go to IDLE.
  - No new accept can happen in that same cycle, so minimum period is BIN_W+2 cycles.
- out_bcd and out_ovf keep their last delivered values outside DONE until the next load.
- Overflow: when out_ovf=1, out_bcd is forced to all digits 4'hE. Digits that carried beyond the top digit are discarded.
- Counter width: $clog2(BIN_W+1). Scratch width: 4*DIGITS + BIN_W.
- No combinational path from any input to any output except in_ready/out_valid, which are decoded from state.

Optional Feature:
- BCD_BLANK_EN defined: on load, every leading zero digit above digit 0 is replaced by 4'hF (display blank code). Digit 0 is never blanked. Overflow code 4'hE is never blanked.
- Not defined: raw BCD including leading zeros.
- State machine and timing are identical in both builds.

Test Plan:
- in_bin=81, out_ready=1 -> out_valid rises exactly 8 cycles after the accept edge, out_bcd=8'h81, out_ovf=0, one-cycle out_valid pulse, then in_ready=1.
- in_bin=7 then in_bin=0 -> with BCD_BLANK_EN: 8'hF7, 8'hF0; without: 8'h07, 8'h00.
- in_bin=200 -> out_ovf=1, out_bcd=8'hEE; next operand 45 -> out_ovf=0, out_bcd=8'h45.
- in_bin=45, out_ready=0 for 5 cycles while in_valid=1 with in_bin=99:
  - out_bcd holds 8'h45, in_ready=0, 99 not accepted;
  - after out_ready pulse, 99 accepted on a later edge -> 8'h99.
- rst=1 for one cycle during the 4th CONV cycle of in_bin=63 -> next cycle state IDLE, out_valid=0, out_bcd=0, busy=0; then in_bin=10 -> 8'h10 after 8 cycles.
- BIN_W=10, DIGITS=4: in_bin=1023 -> out_bcd=16'h1023 after 10 cycles; in_bin=8 with BCD_BLANK_EN -> 16'hFFF8.
